// File: rtl/uart_rx_if.sv
// Bus-side signals of the UART receiver: tick and serial line in, received byte and status out.
// The bench drives through the master modport; the receiver uses the slave modport.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 b_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_busy;
  logic                 frame_err;

  modport master (
    output b_tick, rx,
    input  rx_data, rx_done, rx_busy, frame_err
  );

  modport slave (
    input  b_tick, rx,
    output rx_data, rx_done, rx_busy, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, driven by an oversampling baud tick.
// A start bit is qualified at its midpoint, then every bit is sampled at mid-period.
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       reset,
  uart_rx_if.slave   bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;

  logic rx_s;
  logic tick_mid;
  logic tick_end;
  logic bit_last;

  // Two-flop synchroniser; the line idles high so both flops reset to 1.
  assign sync_d   = {sync_q[0], bus.rx};
  assign rx_s     = sync_q[1];
  assign tick_mid = bus.b_tick && (tick_cnt_q == TICK_MID);
  assign tick_end = bus.b_tick && (tick_cnt_q == TICK_END);
  assign bit_last = (bit_cnt_q == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (tick_mid) state_d = rx_s ? IDLE : DATA;
      DATA:    if (tick_end && bit_last) state_d = STOP;
      STOP:    if (tick_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    frame_err_d = frame_err_q;
    rx_done_d   = 1'b0;
    case (state_q)
      IDLE: tick_cnt_d = '0;
      START: begin
        if (tick_mid) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end else if (bus.b_tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tick_end) begin
          shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
          tick_cnt_d = '0;
          if (!bit_last) bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (bus.b_tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (tick_end) begin
          rx_data_d   = shift_q;
          frame_err_d = ~rx_s;
          rx_done_d   = 1'b1;
          tick_cnt_d  = '0;
        end else if (bus.b_tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      default: tick_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= 2'b11;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are pushed to a scoreboard as they are sent and
// compared when rx_done fires; status and timing corner cases checked inline.
module tb_uart_rx;
  localparam int OS       = 8;
  localparam int DB       = 8;
  localparam int FAST_DIV = 4;
  // 1302 clk/tick would need ~100k clk per frame; a tenth-scale divisor keeps sparse ticks.
  localparam int REAL_DIV = 130;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          done_cnt   = 0;
  int          tick_div   = FAST_DIV;
  logic        busy_after = 1'b0;
  logic [DB:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Baud tick generator: one-clk pulse every tick_div clocks.
  initial begin
    int cnt;
    cnt = 0;
    bus.b_tick = 1'b0;
    forever begin
      @(negedge clk);
      cnt++;
      if (cnt >= tick_div) begin
        cnt = 0;
        bus.b_tick = 1'b1;
      end else begin
        bus.b_tick = 1'b0;
      end
    end
  end

  // Output monitor: pop the scoreboard on every done pulse.
  initial begin
    logic        done_prev;
    logic [DB:0] e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_prev) busy_after = bus.rx_busy;
      if (bus.rx_done) begin
        done_cnt++;
        check("done_width", 32'(done_prev), 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          check("rx_data", 32'(bus.rx_data), 32'(e[DB-1:0]));
          check("frame_err", 32'(bus.frame_err), 32'(e[DB]));
        end
      end
      done_prev = bus.rx_done;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int bits);
    bus.rx = 1'b1;
    repeat (bits * OS * tick_div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_ticks);
    int bc;
    bc = OS * tick_div;
    sb.push_back({~stop_bit, d});
    bus.rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      bus.rx = d[i];
      repeat (bc) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (stop_ticks * tick_div) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 0);
  endtask

  task automatic align_tick(input int offset);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.b_tick && n < 2 * REAL_DIV) begin
      @(negedge clk);
      n++;
    end
    check("tick_seen", 32'(bus.b_tick), 1);
    repeat (offset) @(negedge clk);
  endtask

  initial begin
    int         d0;
    logic [7:0] pat;
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(bus.rx_data), 0);
    check("rst_done", 32'(bus.rx_done), 0);
    check("rst_busy", 32'(bus.rx_busy), 0);
    check("rst_ferr", 32'(bus.frame_err), 0);
    reset = 1'b0;
    idle(2);

    // Normal byte
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1, OS);
    wait_drain(400);
    idle(1);
    check("a5_busy_after_done", 32'(busy_after), 0);
    check("a5_busy", 32'(bus.rx_busy), 0);
    check("a5_count", 32'(done_cnt - d0), 1);

    // Back-to-back frames
    d0 = done_cnt;
    send_frame(8'h00, 1'b1, OS);
    send_frame(8'hFF, 1'b1, OS);
    send_frame(8'h3C, 1'b1, OS);
    wait_drain(400);
    idle(1);
    check("b2b_count", 32'(done_cnt - d0), 3);

    // Start glitch of two ticks
    d0 = done_cnt;
    bus.rx = 1'b0;
    repeat (2 * tick_div) @(negedge clk);
    check("glitch_busy_hi", 32'(bus.rx_busy), 1);
    idle(2);
    check("glitch_busy", 32'(bus.rx_busy), 0);
    check("glitch_count", 32'(done_cnt - d0), 0);
    check("glitch_data", 32'(bus.rx_data), 32'h3C);
    check("glitch_ferr", 32'(bus.frame_err), 0);

    // Framing error, short low stop so the restarted START is rejected as a glitch
    d0 = done_cnt;
    send_frame(8'h55, 1'b0, 5);
    wait_drain(400);
    check("ferr_restart_busy", 32'(busy_after), 1);
    idle(2);
    check("ferr_idle_busy", 32'(bus.rx_busy), 0);
    send_frame(8'h12, 1'b1, OS);
    wait_drain(400);
    idle(1);
    check("ferr_count", 32'(done_cnt - d0), 2);

    // Reset in the middle of data bit 4
    d0  = done_cnt;
    pat = 8'h81;
    bus.rx = 1'b0;
    repeat (OS * tick_div) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = pat[i];
      repeat (OS * tick_div) @(negedge clk);
    end
    bus.rx = pat[4];
    repeat (OS * tick_div / 2) @(negedge clk);
    check("pre_rst_busy", 32'(bus.rx_busy), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_data", 32'(bus.rx_data), 0);
    check("mid_rst_done", 32'(bus.rx_done), 0);
    check("mid_rst_busy", 32'(bus.rx_busy), 0);
    check("mid_rst_ferr", 32'(bus.frame_err), 0);
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    idle(2);
    check("rst_no_done", 32'(done_cnt - d0), 0);
    send_frame(8'h81, 1'b1, OS);
    wait_drain(400);
    idle(1);
    check("rst_count", 32'(done_cnt - d0), 1);

    // Sparse ticks with the line phase offset around the tick grid
    tick_div = REAL_DIV;
    idle(1);
    d0 = done_cnt;
    align_tick(3);
    send_frame(8'h7E, 1'b1, OS);
    idle(1);
    align_tick(REAL_DIV - 3);
    send_frame(8'h7E, 1'b1, OS);
    wait_drain(20000);
    idle(1);
    check("real_count", 32'(done_cnt - d0), 2);
    check("real_busy", 32'(bus.rx_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
